// File: rtl/axil_apb_bridge_mc.sv
// AXI4-Lite slave to multi-slave APB master bridge.
// One AXI-Lite transaction at a time becomes one APB transfer. The address selects one of
// NUM_SLV slaves, each owning a 2^SLV_AW byte window. PSLVERR and timeouts return SLVERR,
// and decode misses return DECERR without any APB activity.
//
// Optional macro AXIL_APB_BRIDGE_APB4_EN adds the M_APB_PSTRB and M_APB_PPROT outputs.
// When it is undefined, WSTRB and AxPROT are ignored and every write is a full-word write.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   S_AXI_AW*/W*/B*       AXI-Lite write channels (AW and W are accepted together)
//   S_AXI_AR*/R*          AXI-Lite read channels
//   M_APB_PADDR           offset within the selected slave window
//   M_APB_PSEL            one-hot slave select
//   M_APB_PENABLE/PWRITE  APB enable and direction
//   M_APB_PWDATA          APB write data
//   M_APB_PRDATA          per-slave read data lanes, slave i at [i*DATA_W +: DATA_W]
//   M_APB_PREADY/PSLVERR  per-slave ready and error
module axil_apb_bridge_mc #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SLV = 4,
  parameter int unsigned SLV_AW  = 12,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [ADDR_W-1:0]         S_AXI_AWADDR,
  input  logic [2:0]                S_AXI_AWPROT,
  input  logic                      S_AXI_AWVALID,
  output logic                      S_AXI_AWREADY,
  input  logic [DATA_W-1:0]         S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]       S_AXI_WSTRB,
  input  logic                      S_AXI_WVALID,
  output logic                      S_AXI_WREADY,
  output logic [1:0]                S_AXI_BRESP,
  output logic                      S_AXI_BVALID,
  input  logic                      S_AXI_BREADY,
  input  logic [ADDR_W-1:0]         S_AXI_ARADDR,
  input  logic [2:0]                S_AXI_ARPROT,
  input  logic                      S_AXI_ARVALID,
  output logic                      S_AXI_ARREADY,
  output logic [DATA_W-1:0]         S_AXI_RDATA,
  output logic [1:0]                S_AXI_RRESP,
  output logic                      S_AXI_RVALID,
  input  logic                      S_AXI_RREADY,
  output logic [SLV_AW-1:0]         M_APB_PADDR,
  output logic [NUM_SLV-1:0]        M_APB_PSEL,
  output logic                      M_APB_PENABLE,
  output logic                      M_APB_PWRITE,
  output logic [DATA_W-1:0]         M_APB_PWDATA,
`ifdef AXIL_APB_BRIDGE_APB4_EN
  output logic [DATA_W/8-1:0]       M_APB_PSTRB,
  output logic [2:0]                M_APB_PPROT,
`endif
  input  logic [NUM_SLV*DATA_W-1:0] M_APB_PRDATA,
  input  logic [NUM_SLV-1:0]        M_APB_PREADY,
  input  logic [NUM_SLV-1:0]        M_APB_PSLVERR
);

  localparam int unsigned IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

  state_e              state_q, state_d;
  logic                run_q;      // low during and one cycle after reset: keeps READYs low
  logic                ptr_q, ptr_d;  // 0: write has priority, 1: read has priority
  logic                wr_q, wr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SLV_AW-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic [15:0]         cnt_q, cnt_d;

  logic                wr_pend, rd_pend, grant_wr, grant_rd;
  logic [ADDR_W-1:0]   req_addr;
  logic [IDX_W-1:0]    req_idx;
  logic                req_miss;
  logic [DATA_W-1:0]   sel_rdata;
  logic                sel_ready, sel_err;
  logic [NUM_SLV-1:0]  psel;

  assign wr_pend  = S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_pend  = S_AXI_ARVALID;
  assign grant_wr = run_q && (state_q == StIdle) && wr_pend && (!rd_pend || !ptr_q);
  assign grant_rd = run_q && (state_q == StIdle) && rd_pend && (!wr_pend || ptr_q);

  assign req_addr = grant_wr ? S_AXI_AWADDR : S_AXI_ARADDR;
  assign req_idx  = req_addr[SLV_AW +: IDX_W];
  assign req_miss = (|(req_addr >> (SLV_AW + IDX_W))) || (32'(req_idx) >= NUM_SLV);

  // Per-slave lane / ready / error mux plus one-hot select, all keyed on the captured index.
  always_comb begin
    sel_rdata = '0;
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    psel      = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_rdata = M_APB_PRDATA[i*DATA_W +: DATA_W];
        sel_ready = M_APB_PREADY[i];
        sel_err   = M_APB_PSLVERR[i];
        psel[i]   = (state_q == StSetup) || (state_q == StAccess);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    wr_d     = wr_q;
    idx_d    = idx_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    resp_d   = resp_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_wr || grant_rd) begin
          ptr_d   = grant_wr;  // next contested slot goes to the other direction
          wr_d    = grant_wr;
          idx_d   = req_idx;
          paddr_d = req_addr[SLV_AW-1:0];
          cnt_d   = '0;
          if (grant_wr) pwdata_d = S_AXI_WDATA;
          if (req_miss) begin
            state_d = StResp;
            resp_d  = 2'b11;
            rdata_d = '0;
          end else begin
            state_d = StSetup;
          end
        end
      end
      StSetup: state_d = StAccess;
      StAccess: begin
        if (sel_ready) begin
          state_d = StResp;
          resp_d  = sel_err ? 2'b10 : 2'b00;
          if (!wr_q) rdata_d = sel_rdata;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          state_d = StResp;
          resp_d  = 2'b10;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StResp: begin
        if ((wr_q && S_AXI_BREADY) || (!wr_q && S_AXI_RREADY)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      run_q    <= 1'b0;
      ptr_q    <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      resp_q   <= 2'b00;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      run_q    <= 1'b1;
      ptr_q    <= ptr_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      resp_q   <= resp_d;
      cnt_q    <= cnt_d;
    end
  end

  assign S_AXI_AWREADY = grant_wr;
  assign S_AXI_WREADY  = grant_wr;
  assign S_AXI_ARREADY = grant_rd;
  assign S_AXI_BVALID  = (state_q == StResp) && wr_q;
  assign S_AXI_RVALID  = (state_q == StResp) && !wr_q;
  assign S_AXI_BRESP   = resp_q;
  assign S_AXI_RRESP   = resp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign M_APB_PADDR   = paddr_q;
  assign M_APB_PSEL    = psel;
  assign M_APB_PENABLE = (state_q == StAccess);
  assign M_APB_PWRITE  = wr_q;
  assign M_APB_PWDATA  = pwdata_q;

`ifdef AXIL_APB_BRIDGE_APB4_EN
  logic [DATA_W/8-1:0] pstrb_q;
  logic [2:0]          pprot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstrb_q <= '0;
      pprot_q <= 3'b000;
    end else if (grant_wr || grant_rd) begin
      pstrb_q <= grant_wr ? S_AXI_WSTRB : '0;
      pprot_q <= grant_wr ? S_AXI_AWPROT : S_AXI_ARPROT;
    end
  end

  assign M_APB_PSTRB = pstrb_q;
  assign M_APB_PPROT = pprot_q;
`else
  logic unused_apb4;
  assign unused_apb4 = ^{S_AXI_WSTRB, S_AXI_AWPROT, S_AXI_ARPROT};
`endif

endmodule

// File: tb/tb_axil_apb_bridge_mc.sv
// Directed self-checking bench for axil_apb_bridge_mc.
// dut uses the default TIMEOUT; dut_to uses TIMEOUT=4 for the abort and mid-transfer reset cases.
module tb_axil_apb_bridge_mc;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  awaddr, wdata, araddr;
  logic [2:0]   awprot, arprot;
  logic [3:0]   wstrb;
  logic         awvalid, wvalid, bready, arvalid, rready;
  logic         awready, wready, bvalid, arready, rvalid;
  logic [1:0]   bresp, rresp;
  logic [31:0]  rdata, pwdata;
  logic [11:0]  paddr;
  logic [3:0]   psel, pready, pslverr;
  logic         penable, pwrite;
  logic [127:0] prdata;

  logic         t_arvalid, t_rready;
  logic         t_awready, t_wready, t_bvalid, t_arready, t_rvalid;
  logic [1:0]   t_bresp, t_rresp;
  logic [31:0]  t_rdata, t_pwdata;
  logic [11:0]  t_paddr;
  logic [3:0]   t_psel;
  logic         t_penable, t_pwrite;
`ifdef AXIL_APB_BRIDGE_APB4_EN
  logic [3:0]   pstrb, t_pstrb;
  logic [2:0]   pprot, t_pprot;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  axil_apb_bridge_mc dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
    .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid),
    .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .M_APB_PADDR(paddr), .M_APB_PSEL(psel), .M_APB_PENABLE(penable), .M_APB_PWRITE(pwrite),
    .M_APB_PWDATA(pwdata),
`ifdef AXIL_APB_BRIDGE_APB4_EN
    .M_APB_PSTRB(pstrb), .M_APB_PPROT(pprot),
`endif
    .M_APB_PRDATA(prdata), .M_APB_PREADY(pready), .M_APB_PSLVERR(pslverr)
  );

  axil_apb_bridge_mc #(.TIMEOUT(4)) dut_to (
    .clk(clk), .rst_n(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(1'b0),
    .S_AXI_AWREADY(t_awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(1'b0), .S_AXI_WREADY(t_wready),
    .S_AXI_BRESP(t_bresp), .S_AXI_BVALID(t_bvalid), .S_AXI_BREADY(1'b0),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(t_arvalid),
    .S_AXI_ARREADY(t_arready),
    .S_AXI_RDATA(t_rdata), .S_AXI_RRESP(t_rresp), .S_AXI_RVALID(t_rvalid),
    .S_AXI_RREADY(t_rready),
    .M_APB_PADDR(t_paddr), .M_APB_PSEL(t_psel), .M_APB_PENABLE(t_penable),
    .M_APB_PWRITE(t_pwrite), .M_APB_PWDATA(t_pwdata),
`ifdef AXIL_APB_BRIDGE_APB4_EN
    .M_APB_PSTRB(t_pstrb), .M_APB_PPROT(t_pprot),
`endif
    .M_APB_PRDATA(prdata), .M_APB_PREADY(pready), .M_APB_PSLVERR(pslverr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic b_ack();
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic r_ack();
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int n_en;
    rst_n = 1'b0;
    awaddr = '0; wdata = '0; araddr = '0; awprot = 3'b0; arprot = 3'b0; wstrb = 4'h0;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    t_arvalid = 1'b0; t_rready = 1'b0;
    prdata = '0; pready = 4'h0; pslverr = 4'h0;

    // Reset: requests pending, every output must still be zero.
    #12;
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Write 0x1004 = 0xDEADBEEF, slave 1 zero-wait.
    awaddr = 32'h0000_1004; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; pready = 4'hF; pslverr = 4'h0;
    #1;
    chk("w1_awready", awready, 1);
    chk("w1_wready", wready, 1);
    chk("w1_arready", arready, 0);
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("w1_setup_psel", psel, 4'b0010);
    chk("w1_setup_penable", penable, 0);
    chk("w1_paddr", paddr, 12'h004);
    chk("w1_pwdata", pwdata, 32'hDEAD_BEEF);
    chk("w1_pwrite", pwrite, 1);
    chk("w1_setup_bvalid", bvalid, 0);
    tick();
    chk("w1_access_penable", penable, 1);
    chk("w1_access_psel", psel, 4'b0010);
    tick();
    chk("w1_bvalid_t3", bvalid, 1);
    chk("w1_bresp", bresp, 2'b00);
    chk("w1_resp_psel", psel, 0);
    b_ack();
    chk("w1_bvalid_cleared", bvalid, 0);

    // Read 0x3010, slave 3 with 5 wait states.
    araddr = 32'h0000_3010; arvalid = 1'b1; pready = 4'h0;
    prdata[3*32 +: 32] = 32'h1234_5678;
    #1;
    chk("r1_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    chk("r1_psel", psel, 4'b1000);
    chk("r1_paddr", paddr, 12'h010);
    chk("r1_pwrite", pwrite, 0);
    k = 1;
    while (!rvalid && k < 40) begin
      tick();
      k++;
      if (k == 7) pready = 4'b1000;
    end
    chk("r1_latency", k, 8);
    chk("r1_rdata", rdata, 32'h1234_5678);
    chk("r1_rresp", rresp, 2'b00);
    r_ack();
    chk("r1_rvalid_cleared", rvalid, 0);

    // Decode miss.
    araddr = 32'h0001_0000; arvalid = 1'b1; pready = 4'hF;
    #1;
    chk("miss_arready", arready, 1);
    tick();
    arvalid = 1'b0;
    chk("miss_rvalid", rvalid, 1);
    chk("miss_psel", psel, 0);
    chk("miss_rresp", rresp, 2'b11);
    chk("miss_rdata", rdata, 0);
    r_ack();

    // Write to slave 2 with PSLVERR.
    awaddr = 32'h0000_2008; wdata = 32'hA5A5_A5A5; awvalid = 1'b1; wvalid = 1'b1;
    pready = 4'b0100; pslverr = 4'b0100;
    #1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("err_psel", psel, 4'b0100);
    k = 1;
    while (!bvalid && k < 40) begin
      tick();
      k++;
    end
    chk("err_latency", k, 3);
    chk("err_bresp", bresp, 2'b10);
    b_ack();
    pslverr = 4'h0;

    // Read slave 1, RREADY held low for 3 cycles.
    araddr = 32'h0000_1000; arvalid = 1'b1; pready = 4'hF;
    prdata[1*32 +: 32] = 32'hCAFE_F00D;
    #1;
    tick();
    arvalid = 1'b0;
    k = 1;
    while (!rvalid && k < 40) begin
      tick();
      k++;
    end
    chk("stall_latency", k, 3);
    prdata[1*32 +: 32] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_rvalid", rvalid, 1);
      chk("stall_rresp", rresp, 2'b00);
      chk("stall_rdata", rdata, 32'hCAFE_F00D);
    end
    r_ack();

    // Fresh reset, then contested write/read pairs.
    rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
    tick();
    for (int p = 0; p < 2; p++) begin
      awaddr = 32'h0000_0100; wdata = 32'h0000_0011; awvalid = 1'b1; wvalid = 1'b1;
      araddr = 32'h0000_1200; arvalid = 1'b1; pready = 4'hF;
      prdata[1*32 +: 32] = 32'h2222_3333;
      #1;
      chk("pair_awready", awready, 1);
      chk("pair_arready_blocked", arready, 0);
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      chk("pair_w_pwrite", pwrite, 1);
      chk("pair_w_psel", psel, 4'b0001);
      k = 1;
      while (!bvalid && k < 40) begin
        tick();
        k++;
      end
      chk("pair_w_bvalid", bvalid, 1);
      b_ack();
      chk("pair_r_arready", arready, 1);
      chk("pair_r_awready", awready, 0);
      tick();
      arvalid = 1'b0;
      chk("pair_r_pwrite", pwrite, 0);
      chk("pair_r_psel", psel, 4'b0010);
      k = 1;
      while (!rvalid && k < 40) begin
        tick();
        k++;
      end
      chk("pair_r_rdata", rdata, 32'h2222_3333);
      r_ack();
    end

    // TIMEOUT=4 instance: one good read so RDATA is nonzero beforehand.
    araddr = 32'h0000_0040; t_arvalid = 1'b1; pready = 4'hF;
    prdata[0 +: 32] = 32'h1111_2222;
    #1;
    chk("to_arready", t_arready, 1);
    tick();
    t_arvalid = 1'b0;
    k = 1;
    while (!t_rvalid && k < 40) begin
      tick();
      k++;
    end
    chk("to_good_rdata", t_rdata, 32'h1111_2222);
    t_rready = 1'b1;
    tick();
    t_rready = 1'b0;

    // Slave 0 never ready: PENABLE for exactly 4 cycles, then SLVERR.
    araddr = 32'h0000_0020; pready = 4'h0; t_arvalid = 1'b1;
    #1;
    tick();
    t_arvalid = 1'b0;
    n_en = 0;
    k = 0;
    while (!t_rvalid && k < 40) begin
      tick();
      k++;
      if (t_penable) n_en++;
    end
    chk("to_penable_cycles", n_en, 4);
    chk("to_rvalid", t_rvalid, 1);
    chk("to_rresp", t_rresp, 2'b10);
    chk("to_rdata", t_rdata, 0);
    chk("to_psel", t_psel, 0);
    pready = 4'hF;
    prdata[0 +: 32] = 32'h9999_9999;
    tick();
    chk("to_late_rresp", t_rresp, 2'b10);
    chk("to_late_rdata", t_rdata, 0);
    t_rready = 1'b1;
    tick();
    t_rready = 1'b0;
    pready = 4'h0;

    // Reset pulsed in the middle of a second ACCESS.
    t_arvalid = 1'b1;
    #1;
    tick();
    t_arvalid = 1'b0;
    tick();
    chk("mid_penable_pre", t_penable, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_psel", t_psel, 0);
    chk("mid_penable", t_penable, 0);
    chk("mid_rvalid", t_rvalid, 0);
    chk("mid_arready", t_arready, 0);
    chk("mid_paddr", t_paddr, 0);
    chk("mid_rdata", t_rdata, 0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_no_resp", t_rvalid, 0);
    chk("mid_no_apb", t_psel, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_apb_bridge_mc.md
Name: axil_apb_bridge_mc

Overview:
AXI4-Lite slave to multi-slave APB master bridge. It is the parametrised successor of the fixed 32-bit single-APB dual-interface shell, and adds a real protocol engine.
- Converts one AXI4-Lite transaction at a time into one APB transfer.
- Decodes the address to one of NUM_SLV APB slaves.
- Maps PSLVERR, decode misses and stalled slaves to AXI error responses.
- Sits between the AXI-Lite interconnect and the peripheral APB segment.

Parameters:
ADDR_W, 32, AXI address width.
DATA_W, 32, data width; must be 32 or 64.
NUM_SLV, 4, number of APB slaves (1..16); IDX_W = max(1, clog2(NUM_SLV)).
SLV_AW, 12, per-slave window size is 2^SLV_AW bytes; also the width of PADDR.
TIMEOUT, 255, maximum ACCESS-phase wait cycles (1..65535).

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_W/3/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_W/DATA_W/8/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_W/3/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_W/2/1/1  read data channel
M_APB_PADDR  out  SLV_AW  offset within the selected slave window
M_APB_PSEL  out  NUM_SLV  one-hot slave select
M_APB_PENABLE/PWRITE  out  1/1  APB enable / direction
M_APB_PWDATA  out  DATA_W  write data
M_APB_PRDATA  in  NUM_SLV*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W]
M_APB_PREADY/PSLVERR  in  NUM_SLV/NUM_SLV  per-slave ready / error

Behaviour:
- Reset (async assert, sync release) clears all outputs:
  - All READY/VALID outputs, PSEL, PENABLE and PWRITE = 0.
  - BRESP, RRESP, RDATA, PADDR and PWDATA = 0.
  - FSM = IDLE; arbitration pointer = write.
- FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
- IDLE, request detection and arbitration:
  - A write is pending when AWVALID & WVALID are both high; AW and W are always accepted together.
  - A read is pending when ARVALID is high.
  - If only one is pending, serve it. If both are pending, serve the one the pointer selects, then toggle the pointer (round-robin).
  - Grant: the granted READY(s) go high combinationally in IDLE. Address, data and strobe are captured on the handshake edge.
- Address decode: idx = addr[SLV_AW +: IDX_W].
  - Miss when any addr bit at or above SLV_AW+IDX_W is nonzero, or idx >= NUM_SLV.
  - On a miss: go directly to RESP with DECERR 2'b11. No APB activity; RDATA = 0.
- SETUP (1 cycle): PSEL[idx]=1, PENABLE=0. PADDR, PWRITE and PWDATA are valid here and held stable through ACCESS.
- ACCESS: PENABLE=1 and the wait counter increments.
  - Completes on the first cycle PREADY[idx]=1. PSEL and PENABLE drop on the next edge.
  - Response: PSLVERR[idx]=1 gives SLVERR 2'b10; otherwise OKAY 2'b00.
  - For reads, RDATA is captured from slave idx's lane on the completing edge.
- Timeout: if the counter reaches TIMEOUT without PREADY, abort.
  - PSEL and PENABLE drop; response = SLVERR; RDATA = 0.
  - Any PREADY arriving later is ignored.
- RESP: BVALID or RVALID is held, with RESP/DATA stable, until BREADY or RREADY. Return to IDLE on that handshake edge.
- Latency with a zero-wait slave: handshake at cycle T, SETUP T+1, ACCESS T+2, VALID from T+3. Throughput is at most one transfer per 4 cycles.
- AXPROT is ignored unless the optional feature is compiled in.
- A reset asserted mid-transfer aborts immediately. No response is issued for the aborted transaction.

Optional Feature:
AXIL_APB_BRIDGE_APB4_EN
- Defined: adds outputs M_APB_PSTRB [DATA_W/8] = captured WSTRB (all-zero for reads) and M_APB_PPROT [3] = captured AWPROT/ARPROT. Both are valid in SETUP and ACCESS and are 0 at reset.
- Undefined: neither port exists; WSTRB and PROT are discarded. A write with any WSTRB bit low is still performed as a full-word write.

Test Plan:
- Write 0x0000_1004 = 0xDEADBEEF, WSTRB=0xF, slave 1 zero-wait -> PSEL=4'b0010, PADDR=0x004, PWDATA=0xDEADBEEF; BVALID at T+3, BRESP=00.
- Read 0x0000_3010, slave 3 adds 5 wait states, PRDATA=0x12345678 -> RVALID at T+8, RDATA=0x12345678, RRESP=00.
- Read 0x0001_0000 (decode miss) -> no PSEL activity; RRESP=11, RDATA=0.
- Write to slave 2 with PSLVERR=1 on the ready cycle -> BRESP=10; RREADY held low for 3 cycles keeps RVALID/RRESP stable on a following read.
- Simultaneous AW+W and AR after reset -> write served first, read next. Repeat the pair -> write first again, because the pointer toggled back.
- TIMEOUT=4, slave 0 never ready -> PENABLE high exactly 4 cycles, then RRESP=10. rst_n pulsed during a second ACCESS -> all outputs 0 immediately.
